// File: rtl/riscv_uart_loader.sv
// UART boot loader: receives 0xA5-framed little-endian word streams and drives the upg_* programming port.
// Optional trailing XOR checksum per frame is enabled by defining RISCV_UART_LOADER_CHECKSUM_EN.
module riscv_uart_loader #(
    parameter int CLK_FREQ = 10000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    output logic        upg_clk_o,
    output logic        upg_rst_o,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        err_o
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

`ifdef RISCV_UART_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_TGT, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR} st_t;
    localparam st_t FRAME_END = S_CHK;
`else
    typedef enum logic [2:0] {S_IDLE, S_TGT, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} st_t;
    localparam st_t FRAME_END = S_IDLE;
`endif

    // ---------------- RX front end ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;

    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                // Short low glitches are rejected by re-checking the start bit mid-bit.
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d        = '0;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                    rx_state_d   = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_i;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ---------------- Frame FSM ----------------
    st_t         st_q, st_d;
    logic        tgt_q, tgt_d;
    logic [15:0] len_q, len_d;
    logic [13:0] addr_q, addr_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] word_q, word_d;
    logic        wen_q, wen_d;
    logic [14:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        prg_rst_q, prg_rst_d;
    logic [15:0] len_rx;
    logic [7:0]  rx_byte;
`ifdef RISCV_UART_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif

    assign rx_byte = shift_q;
    assign len_rx  = {rx_byte, len_q[7:0]};

    always_comb begin
        st_d      = st_q;
        tgt_d     = tgt_q;
        len_d     = len_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        word_d    = word_q;
        wen_d     = 1'b0;
        adr_d     = adr_q;
        dat_d     = dat_q;
        prg_rst_d = prg_rst_q;
`ifdef RISCV_UART_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        // DONE and ERR are terminal; a framing error elsewhere aborts programming.
        if (frame_err_q && st_q != S_DONE && st_q != S_ERR) begin
            st_d = S_ERR;
        end else if (byte_valid_q) begin
            case (st_q)
                S_IDLE: begin
                    if (rx_byte == 8'hA5) begin
                        st_d      = S_TGT;
                        prg_rst_d = 1'b0;
                    end
                end
                S_TGT: begin
                    if (rx_byte == 8'h00 || rx_byte == 8'h01) begin
                        tgt_d = rx_byte[0];
                        st_d  = S_LEN0;
`ifdef RISCV_UART_LOADER_CHECKSUM_EN
                        xor_d = 8'h00;
`endif
                    end else if (rx_byte == 8'hFF) begin
                        st_d = S_DONE;
                    end else begin
                        st_d = S_ERR;
                    end
                end
                S_LEN0: begin
                    len_d[7:0] = rx_byte;
                    st_d       = S_LEN1;
                end
                S_LEN1: begin
                    if (len_rx > 16'd16384) begin
                        st_d = S_ERR;
                    end else if (len_rx == 16'd0) begin
                        st_d = FRAME_END;
                    end else begin
                        len_d  = len_rx;
                        addr_d = '0;
                        idx_d  = '0;
                        st_d   = S_DATA;
                    end
                end
                S_DATA: begin
`ifdef RISCV_UART_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ rx_byte;
`endif
                    case (idx_q)
                        2'd0: word_d[7:0]   = rx_byte;
                        2'd1: word_d[15:8]  = rx_byte;
                        2'd2: word_d[23:16] = rx_byte;
                        default: begin
                            wen_d  = 1'b1;
                            dat_d  = {rx_byte, word_q};
                            adr_d  = {tgt_q, addr_q};
                            addr_d = addr_q + 1'b1;
                            len_d  = len_q - 1'b1;
                            if (len_q == 16'd1) begin
                                st_d = FRAME_END;
                            end
                        end
                    endcase
                    idx_d = idx_q + 1'b1;
                end
`ifdef RISCV_UART_LOADER_CHECKSUM_EN
                S_CHK: st_d = (rx_byte == xor_q) ? S_IDLE : S_ERR;
`endif
                default: st_d = st_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q      <= S_IDLE;
            tgt_q     <= 1'b0;
            len_q     <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            wen_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            prg_rst_q <= 1'b1;
`ifdef RISCV_UART_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            st_q      <= st_d;
            tgt_q     <= tgt_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            wen_q     <= wen_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            prg_rst_q <= prg_rst_d;
`ifdef RISCV_UART_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign upg_clk_o  = clk;
    assign upg_rst_o  = prg_rst_q;
    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = (st_q == S_DONE);
    assign err_o      = (st_q == S_ERR);

endmodule

// File: tb/tb_riscv_uart_loader.sv
// Directed bench for riscv_uart_loader: serial byte frames in, upg_* write log checked against hand-computed values.
`timescale 1ns/1ps
module tb_riscv_uart_loader;

    localparam int CLK_FREQ = 10000000;
    localparam int BAUD     = 1000000;
    localparam int DIV      = CLK_FREQ / BAUD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_i = 1'b1;
    logic        upg_clk_o, upg_rst_o, upg_wen_o, upg_done_o, err_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;

    riscv_uart_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .upg_clk_o  (upg_clk_o),
        .upg_rst_o  (upg_rst_o),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .err_o      (err_o)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [14:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    int          run_len = 0;
    int          max_run = 0;

    // Write monitor: logs every strobe cycle and tracks the longest strobe run.
    initial begin
        forever begin
            @(negedge clk);
            if (upg_wen_o) begin
                wr_adr.push_back(upg_adr_o);
                wr_dat.push_back(upg_dat_o);
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-14s got 0x%08h expected 0x%08h ok", tag, obs, exp);
        end else begin
            $display("FAIL %-14s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bit_time();
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            bit_time();
        end
        rx_i = stop_bit;
        bit_time();
        rx_i = 1'b1;
        if (!stop_bit) bit_time();
    endtask

    // Sends n bytes; the first byte is the most significant of the n used.
    task automatic send_seq(input logic [95:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(v[8*(n-1-i) +: 8], 1'b1);
        end
    endtask

    task automatic send_chk(input logic [7:0] x);
`ifdef RISCV_UART_LOADER_CHECKSUM_EN
        send_byte(x, 1'b1);
`else
        if (x === 8'hxx) $display("unreachable");
`endif
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
        max_run = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_urst"}, {31'd0, upg_rst_o}, 32'd1);
        check({tag, "_wen"},  {31'd0, upg_wen_o}, 32'd0);
        check({tag, "_adr"},  {17'd0, upg_adr_o}, 32'd0);
        check({tag, "_dat"},  upg_dat_o, 32'd0);
        check({tag, "_done"}, {31'd0, upg_done_o}, 32'd0);
        check({tag, "_err"},  {31'd0, err_o}, 32'd0);
    endtask

    task automatic do_reset();
        rx_i = 1'b1;
        rst  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear_log();
    endtask

    initial begin
        rst  = 1'b0;
        rx_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear_log();

        // Single instruction word.
        send_seq({8'hA5}, 1);
        settle();
        check("urst_fall", {31'd0, upg_rst_o}, 32'd0);
        send_seq({8'h00, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00}, 7);
        send_chk(8'h13);
        settle();
        check("f1_count", wr_adr.size(), 32'd1);
        if (wr_adr.size() >= 1) begin
            check("f1_adr", {17'd0, wr_adr[0]}, 32'h0000);
            check("f1_dat", wr_dat[0], 32'h00000013);
        end

        // Two data words, then end-of-programming.
        clear_log();
        send_seq({8'hA5, 8'h01, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12}, 12);
        send_chk(8'h2A);
        settle();
        check("f2_count", wr_adr.size(), 32'd2);
        if (wr_adr.size() >= 2) begin
            check("f2_adr0", {17'd0, wr_adr[0]}, 32'h4000);
            check("f2_dat0", wr_dat[0], 32'hDEADBEEF);
            check("f2_adr1", {17'd0, wr_adr[1]}, 32'h4001);
            check("f2_dat1", wr_dat[1], 32'h12345678);
        end
        check("wen_width", max_run, 32'd1);
        check("hold_adr", {17'd0, upg_adr_o}, 32'h4001);
        send_seq({8'hA5, 8'hFF}, 2);
        settle();
        check("done", {31'd0, upg_done_o}, 32'd1);
        clear_log();
        send_seq({8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04}, 8);
        settle();
        check("post_done_wr", wr_adr.size(), 32'd0);
        check("post_done_dn", {31'd0, upg_done_o}, 32'd1);
        check("post_done_er", {31'd0, err_o}, 32'd0);

        // Leading garbage and an empty frame, then a real write proves IDLE.
        do_reset();
        send_seq({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00}, 7);
        send_chk(8'h00);
        settle();
        check("garb_wr", wr_adr.size(), 32'd0);
        check("garb_err", {31'd0, err_o}, 32'd0);
        send_seq({8'hA5, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 8);
        send_chk(8'h00);
        settle();
        check("garb_f_cnt", wr_adr.size(), 32'd1);
        if (wr_adr.size() >= 1) check("garb_f_dat", wr_dat[0], 32'hDDCCBBAA);

        // Bad target and oversize length.
        do_reset();
        send_seq({8'hA5, 8'h07}, 2);
        settle();
        check("bad_tgt_err", {31'd0, err_o}, 32'd1);
        do_reset();
        send_seq({8'hA5, 8'h00, 8'h01, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04}, 8);
        settle();
        check("big_len_err", {31'd0, err_o}, 32'd1);
        check("big_len_wr", wr_adr.size(), 32'd0);
        do_reset();
        send_seq({8'hA5, 8'h00, 8'h00, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04}, 8);
        settle();
        check("max_len_err", {31'd0, err_o}, 32'd0);
        check("max_len_wr", wr_adr.size(), 32'd1);

        // Framing error on the 3rd data byte.
        do_reset();
        send_seq({8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22}, 6);
        send_byte(8'h33, 1'b0);
        send_seq({8'h44}, 1);
        settle();
        check("frm_err", {31'd0, err_o}, 32'd1);
        check("frm_wr", wr_adr.size(), 32'd0);

        // Quarter-bit glitch inside a word must not be taken as a byte.
        do_reset();
        send_seq({8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03}, 7);
        rx_i = 1'b0;
        repeat (DIV / 4) @(posedge clk);
        #1;
        rx_i = 1'b1;
        settle();
        check("glitch_nowr", wr_adr.size(), 32'd0);
        send_seq({8'h04}, 1);
        send_chk(8'h04);
        settle();
        check("glitch_cnt", wr_adr.size(), 32'd1);
        if (wr_adr.size() >= 1) check("glitch_dat", wr_dat[0], 32'h04030201);
        check("glitch_err", {31'd0, err_o}, 32'd0);

        // Reset in the middle of the second data word.
        do_reset();
        send_seq({8'hA5, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB}, 10);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear_log();
        send_seq({8'hA5, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 8);
        send_chk(8'h22);
        settle();
        check("midrst_cnt", wr_adr.size(), 32'd1);
        if (wr_adr.size() >= 1) begin
            check("midrst_adr", {17'd0, wr_adr[0]}, 32'h0000);
            check("midrst_dat", wr_dat[0], 32'hDEADBEEF);
        end

`ifdef RISCV_UART_LOADER_CHECKSUM_EN
        do_reset();
        send_seq({8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04}, 9);
        settle();
        check("chk_ok_err", {31'd0, err_o}, 32'd0);
        send_seq({8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 9);
        settle();
        check("chk_bad_err", {31'd0, err_o}, 32'd1);
        check("chk_bad_wr", wr_adr.size(), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_uart_loader.md
Name: riscv_uart_loader

Overview:
UART boot loader that sits directly upstream of the data-memory I/O bridge and the instruction memory. It receives a framed byte stream on a serial RX pin, assembles little-endian 32-bit words, and drives the upg_* programming interface (write enable, address, data, done). Memory selection uses address bit 14: 0 selects instruction memory, 1 selects data memory.

Parameters:
CLK_FREQ, 10000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; DIV = CLK_FREQ/BAUD clocks per bit, must be >= 4

Ports:
clk  input  1  system clock; also the programming clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
rx_i  input  1  UART serial input, 8N1, idle high; asynchronous to clk
upg_clk_o  output  1  equals clk (pass-through)
upg_rst_o  output  1  active-high programming reset for memories
upg_wen_o  output  1  one-cycle word write strobe
upg_adr_o  output  15  bit14 = target (0 instr, 1 data); [13:0] = word address
upg_dat_o  output  32  write data
upg_done_o  output  1  programming finished, sticky
err_o  output  1  protocol or framing error, sticky

Behaviour:
- Reset values (rst=0): upg_rst_o=1, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, err_o=0, FSM=IDLE, RX=idle. Reset mid-frame discards all partial state.
- RX front end: rx_i passes through a 2-flop synchroniser. A falling edge starts a bit counter. The start bit is re-checked at DIV/2: if high, abort silently and return to RX idle. The 8 data bits (LSB first) are sampled at bit centres. The stop bit is sampled at its centre: 1 gives a byte_valid pulse for one clk; 0 is a framing error, which sets err_o and forces FSM=ERR.
- Frame format: 0xA5, TGT, LEN_LO, LEN_HI, then LEN words of 4 bytes each, LSB byte first. Multiple frames may follow each other. TGT=0xFF ends programming.
- FSM states: IDLE, TGT, LEN0, LEN1, DATA, [CHK], DONE, ERR.
  - IDLE: any byte other than 0xA5 is ignored. 0xA5 -> TGT.
  - TGT: 0x00 or 0x01 latches the target bit and goes to LEN0. 0xFF goes to DONE. Any other value goes to ERR.
  - LEN0 -> LEN1: latch the 16-bit count N. At the end of LEN1:
    - N > 16384 -> ERR.
    - N = 0 -> IDLE (or CHK if enabled).
    - Otherwise -> DATA, with word address cleared to 0 and byte index 0.
  - DATA: bytes shift into the word at [8*idx+7:8*idx]. On the 4th byte, the cycle after byte_valid: upg_wen_o=1 for exactly one cycle, with upg_dat_o = assembled word and upg_adr_o = {tgt, addr}. adr/dat hold until the next write. Then addr increments and N decrements. N reaching 0 -> IDLE (or CHK).
  - DONE: upg_done_o=1, sticky; further RX bytes are ignored.
  - ERR: err_o=1; upg_wen_o is never asserted again. Only reset leaves ERR or DONE.
- upg_rst_o falls to 0 on the first accepted 0xA5 header and stays 0 until reset.
- Simultaneous events: a framing error on the 4th data byte suppresses that write.

Optional Feature:
RISCV_UART_LOADER_CHECKSUM_EN:
- Defined: each frame with a 0x00/0x01 target carries one trailing byte equal to the XOR of all its data bytes (0x00 when N=0). State CHK compares this byte: match -> IDLE, mismatch -> ERR. Words already written are not rolled back.
- Undefined: no CHK state; frames end after the last word.

Test Plan:
- CLK_FREQ=10000000, BAUD=1000000. Send A5 00 01 00 13 00 00 00 -> one upg_wen_o pulse with upg_adr_o=0x0000, upg_dat_o=0x00000013; upg_rst_o falls after the A5 byte.
- Send A5 01 02 00 EF BE AD DE 78 56 34 12 -> writes {0x4000, 0xDEADBEEF} then {0x4001, 0x12345678}. Then A5 FF -> upg_done_o=1; a further A5 00 01 00 … produces no writes.
- Leading garbage 00 FF 5A before A5 00 00 00 -> ignored; no write; FSM returns to IDLE; err_o=0.
- A5 07 -> err_o=1. A5 00 01 40 (N=16385) -> err_o=1. Neither produces a write.
- Framing error (stop bit held 0) on the 3rd data byte -> err_o=1, no write. A 1/4-bit low glitch on idle rx_i -> no byte is received.
- Assert rst in the middle of a DATA word, then send a clean frame -> outputs return to reset values; the first write goes to address 0 with correct data. With CHECKSUM_EN: a correct XOR byte -> err_o=0; an XOR byte off by one -> err_o=1.
